// File: rtl/rip_const.sv
// rtl/rip_const.sv - shared constants for the rip memory subsystem
package rip_const;

    // Bits per byte lane on every line-wide data bus in the subsystem.
    localparam int B_WIDTH = 8;

endpackage

// File: rtl/rip_mem_arbiter_const.sv
// rtl/rip_mem_arbiter_const.sv - state encoding and helpers for rip_mem_arbiter
package rip_mem_arbiter_const;

    // One transaction in flight: pick in IDLE, present on the master in ISSUE,
    // then wait for the master's completion in WAIT.
    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_W_ISSUE = 3'd1,
        ARB_W_WAIT  = 3'd2,
        ARB_R_ISSUE = 3'd3,
        ARB_R_WAIT  = 3'd4
    } arb_state_t;

    // True while the master-side request strobe is being presented.
    function automatic logic arb_is_issue(input arb_state_t s);
        return (s == ARB_W_ISSUE) || (s == ARB_R_ISSUE);
    endfunction

    // True for either phase of a read transaction.
    function automatic logic arb_is_read(input arb_state_t s);
        return (s == ARB_R_ISSUE) || (s == ARB_R_WAIT);
    endfunction

    // True for either phase of a write transaction.
    function automatic logic arb_is_write(input arb_state_t s);
        return (s == ARB_W_ISSUE) || (s == ARB_W_WAIT);
    endfunction

endpackage

// File: rtl/rip_rr_picker.sv
// rtl/rip_rr_picker.sv - combinational round-robin picker
module rip_rr_picker #(
    parameter int  NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    // Scan from the requester after last_grant, wrapping, and take the first
    // one that is asking; the previous winner is therefore checked last.
    always_comb begin
        int   idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rip_mem_arbiter.sv
// rtl/rip_mem_arbiter.sv - single-outstanding round-robin arbiter in front of rip_axi_master
module rip_mem_arbiter
    import rip_const::*;
    import rip_mem_arbiter_const::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,

    // requester side, requester i at slice i
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         req_addr,
    input  logic [NUM_REQ*LINE_SIZE*B_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*LINE_SIZE-1:0]          req_wstrb,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [NUM_REQ-1:0]                    resp_valid,
    output logic [LINE_SIZE*B_WIDTH-1:0]          resp_rdata,

    // master side
    input  logic                                  wready,
    input  logic                                  wdone,
    input  logic                                  rready,
    input  logic                                  rdone,
    input  logic [LINE_SIZE*B_WIDTH-1:0]          rdata,
    output logic [ADDR_WIDTH-1:0]                 waddr,
    output logic [ADDR_WIDTH-1:0]                 raddr,
    output logic [LINE_SIZE*B_WIDTH-1:0]          wdata,
    output logic [LINE_SIZE-1:0]                  wstrb,
    output logic                                  wvalid,
    output logic                                  rvalid
);

    localparam int D_WIDTH = LINE_SIZE * B_WIDTH;
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           state_q;
    arb_state_t           state_d;

    logic [IDX_W-1:0]     last_grant_q;
    logic [IDX_W-1:0]     grant_q;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 grant_fire;

    logic                 done_pend_q;
    logic                 done_early;
    logic                 complete;

    logic [NUM_REQ-1:0]   resp_valid_q;
    logic [D_WIDTH-1:0]   resp_rdata_q;

    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [D_WIDTH-1:0]    wdata_q;
    logic [LINE_SIZE-1:0]  wstrb_q;

    rip_rr_picker #(
        .NUM_REQ    (NUM_REQ)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt        (pick_gnt),
        .gnt_idx    (pick_idx)
    );

    // A grant happens only from IDLE, and never while reset is held so that
    // no accept pulse leaks out during a reset cycle.
    assign grant_fire = (state_q == ARB_IDLE) && (|req_valid) && !rst;

    // Completion seen while the strobe is still being presented; it is parked
    // in done_pend_q and finished from the WAIT state one cycle later.
    assign done_early = ((state_q == ARB_W_ISSUE) && wdone) ||
                        ((state_q == ARB_R_ISSUE) && rdone);

    // The transaction completes in WAIT on a fresh or a parked done.
    assign complete = ((state_q == ARB_W_WAIT) && (wdone || done_pend_q)) ||
                      ((state_q == ARB_R_WAIT) && (rdone || done_pend_q));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: pick, present until accepted, wait for done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_fire) begin
                    state_d = req_we[pick_idx] ? ARB_W_ISSUE : ARB_R_ISSUE;
                end
            end
            ARB_W_ISSUE: begin
                if (wready) begin
                    state_d = ARB_W_WAIT;
                end
            end
            ARB_W_WAIT: begin
                if (wdone || done_pend_q) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_R_ISSUE: begin
                if (rready) begin
                    state_d = ARB_R_WAIT;
                end
            end
            ARB_R_WAIT: begin
                if (rdone || done_pend_q) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Outputs decoded from state: accept pulse in IDLE, strobes in ISSUE.
    always_comb begin
        req_ready = '0;
        wvalid    = 1'b0;
        rvalid    = 1'b0;
        if (grant_fire) begin
            req_ready = pick_gnt;
        end
        if (arb_is_issue(state_q)) begin
            wvalid = (state_q == ARB_W_ISSUE);
            rvalid = (state_q == ARB_R_ISSUE);
        end
    end

    // Grant bookkeeping and capture of the winner's request fields; the
    // write and read address registers are separate so each keeps its own
    // last value while the other direction is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
            waddr_q      <= '0;
            raddr_q      <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else if (grant_fire) begin
            last_grant_q <= pick_idx;
            grant_q      <= pick_idx;
            if (req_we[pick_idx]) begin
                waddr_q <= req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= req_wdata[int'(pick_idx)*D_WIDTH +: D_WIDTH];
                wstrb_q <= req_wstrb[int'(pick_idx)*LINE_SIZE +: LINE_SIZE];
            end else begin
                raddr_q <= req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Park an early done so it is not lost; cleared once WAIT consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_pend_q <= 1'b0;
        end else if (done_early) begin
            done_pend_q <= 1'b1;
        end else if (!arb_is_issue(state_q)) begin
            done_pend_q <= 1'b0;
        end
    end

    // One-cycle completion pulse routed only to the requester that was granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= '0;
        end else begin
            resp_valid_q <= '0;
            if (complete) begin
                resp_valid_q[grant_q] <= 1'b1;
            end
        end
    end

    // Read data is captured whenever the master reports a read done, early or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rdata_q <= '0;
        end else if (arb_is_read(state_q) && rdone) begin
            resp_rdata_q <= rdata;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign waddr      = waddr_q;
    assign raddr      = raddr_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;

endmodule

// File: tb/tb_rip_mem_arbiter.sv
// tb/tb_rip_mem_arbiter.sv - directed self-checking bench for rip_mem_arbiter
module tb_rip_mem_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 32;
    localparam int LS      = 4;
    localparam int DW      = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_we;
    logic [NUM_REQ*AW-1:0]    req_addr;
    logic [NUM_REQ*DW-1:0]    req_wdata;
    logic [NUM_REQ*LS-1:0]    req_wstrb;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [DW-1:0]            resp_rdata;
    logic                     wready;
    logic                     wdone;
    logic                     rready;
    logic                     rdone;
    logic [DW-1:0]            rdata;
    logic [AW-1:0]            waddr;
    logic [AW-1:0]            raddr;
    logic [DW-1:0]            wdata;
    logic [LS-1:0]            wstrb;
    logic                     wvalid;
    logic                     rvalid;

    int n_chk  = 0;
    int n_pass = 0;
    int w;

    always #5 clk = ~clk;

    rip_mem_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (AW),
        .LINE_SIZE  (LS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .wready     (wready),
        .wdone      (wdone),
        .rready     (rready),
        .rdone      (rdone),
        .rdata      (rdata),
        .waddr      (waddr),
        .raddr      (raddr),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .rvalid     (rvalid)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clr_master;
        wready = 1'b0;
        wdone  = 1'b0;
        rready = 1'b0;
        rdone  = 1'b0;
        rdata  = '0;
    endtask

    task automatic clr_req;
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_wstrb[i*LS +: LS] = s;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        clr_req();
        clr_master();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        clr_req();
        clr_master();
        tick();
        tick();
        #1;
        chk_eq("rst_wvalid",     wvalid,     0);
        chk_eq("rst_rvalid",     rvalid,     0);
        chk_eq("rst_req_ready",  req_ready,  0);
        chk_eq("rst_resp_valid", resp_valid, 0);
        chk_eq("rst_waddr",      waddr,      0);
        chk_eq("rst_raddr",      raddr,      0);
        chk_eq("rst_wdata",      wdata,      0);
        chk_eq("rst_wstrb",      wstrb,      0);
        chk_eq("rst_resp_rdata", resp_rdata, 0);

        // single read, rdone four cycles after the rready cycle
        tick();
        rst = 1'b0;
        set_req(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        #1 chk_eq("rd_ready", req_ready, 2'b01);
        tick();
        clr_req();
        rready = 1'b1;
        #1 chk_eq("rd_rvalid", rvalid, 1);
        chk_eq("rd_raddr", raddr, 32'h0000_1000);
        chk_eq("rd_ready_drop", req_ready, 0);
        tick();
        rready = 1'b0;
        #1 chk_eq("rd_rvalid_drop", rvalid, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            #1 chk_eq("rd_wait_resp", resp_valid, 0);
        end
        tick();
        rdone = 1'b1;
        rdata = 32'hDEAD_BEEF;
        #1 chk_eq("rd_done_cyc_resp", resp_valid, 0);
        tick();
        clr_master();
        #1 chk_eq("rd_resp_valid", resp_valid, 2'b01);
        chk_eq("rd_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
        tick();
        #1 chk_eq("rd_resp_once", resp_valid, 0);

        // fairness: both requesters keep reading
        apply_reset();
        set_req(0, 1'b0, 32'h0000_00A0, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h0000_00B0, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            w = i % 2;
            #1 chk_eq($sformatf("fair%0d_ready", i), req_ready, 64'(1 << w));
            tick();
            rready = 1'b1;
            #1 chk_eq($sformatf("fair%0d_raddr", i), raddr, (w == 1) ? 32'hB0 : 32'hA0);
            tick();
            rready = 1'b0;
            rdone  = 1'b1;
            rdata  = 32'h100 + 32'(i);
            #1 chk_eq($sformatf("fair%0d_rvalid_drop", i), rvalid, 0);
            tick();
            clr_master();
            if (i == 3) clr_req();
            #1 chk_eq($sformatf("fair%0d_resp", i), resp_valid, 64'(1 << w));
            chk_eq($sformatf("fair%0d_rdata", i), resp_rdata, 32'h100 + 32'(i));
        end
        #1 chk_eq("fair_idle_ready", req_ready, 0);

        // write from req1 with three cycles of backpressure
        tick();
        set_req(1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011);
        #1 chk_eq("wr_ready", req_ready, 2'b10);
        tick();
        clr_req();
        req_addr  = '1;
        req_wdata = '1;
        req_wstrb = '1;
        for (int k = 0; k < 4; k++) begin
            wready = (k == 3);
            #1 chk_eq($sformatf("wr_wvalid%0d", k), wvalid, 1);
            chk_eq($sformatf("wr_waddr%0d", k), waddr, 32'h0000_2000);
            chk_eq($sformatf("wr_wdata%0d", k), wdata, 32'h1234_5678);
            chk_eq($sformatf("wr_wstrb%0d", k), wstrb, 4'b0011);
            tick();
        end
        wready = 1'b0;
        #1 chk_eq("wr_wvalid_drop", wvalid, 0);
        tick();
        wdone = 1'b1;
        #1 chk_eq("wr_done_cyc_resp", resp_valid, 0);
        tick();
        wdone = 1'b0;
        #1 chk_eq("wr_resp_valid", resp_valid, 2'b10);
        tick();
        #1 chk_eq("wr_resp_once", resp_valid, 0);
        chk_eq("wr_waddr_hold", waddr, 32'h0000_2000);

        // early done: rdone in the same cycle as rready
        tick();
        set_req(0, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
        #1 chk_eq("ed_ready", req_ready, 2'b01);
        tick();
        clr_req();
        rready = 1'b1;
        rdone  = 1'b1;
        rdata  = 32'hCAFE_F00D;
        #1 chk_eq("ed_rvalid", rvalid, 1);
        chk_eq("ed_raddr", raddr, 32'h0000_3000);
        tick();
        clr_master();
        #1 chk_eq("ed_rvalid_drop", rvalid, 0);
        chk_eq("ed_resp_early", resp_valid, 0);
        tick();
        #1 chk_eq("ed_resp_valid", resp_valid, 2'b01);
        chk_eq("ed_resp_rdata", resp_rdata, 32'hCAFE_F00D);
        for (int k = 0; k < 2; k++) begin
            tick();
            #1 chk_eq($sformatf("ed_resp_once%0d", k), resp_valid, 0);
        end

        // reset during R_WAIT
        tick();
        set_req(0, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
        #1 chk_eq("mr_ready", req_ready, 2'b01);
        tick();
        clr_req();
        rready = 1'b1;
        #1 chk_eq("mr_rvalid", rvalid, 1);
        tick();
        rready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        rdone = 1'b1;
        rdata = 32'h0000_BAD0;
        #1 chk_eq("mr_rvalid0", rvalid, 0);
        chk_eq("mr_wvalid0", wvalid, 0);
        chk_eq("mr_raddr0", raddr, 0);
        chk_eq("mr_waddr0", waddr, 0);
        chk_eq("mr_wdata0", wdata, 0);
        chk_eq("mr_wstrb0", wstrb, 0);
        chk_eq("mr_resp0", resp_valid, 0);
        chk_eq("mr_rdata0", resp_rdata, 0);
        tick();
        clr_master();
        set_req(0, 1'b0, 32'h0000_4100, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h0000_4200, 32'h0, 4'h0);
        #1 chk_eq("mr_no_resp", resp_valid, 0);
        chk_eq("mr_first_grant", req_ready, 2'b01);
        tick();
        clr_req();
        rready = 1'b1;
        rdone  = 1'b1;
        rdata  = 32'h0000_0077;
        #1 chk_eq("mr_raddr", raddr, 32'h0000_4100);
        tick();
        clr_master();
        tick();
        #1 chk_eq("mr_resp", resp_valid, 2'b01);
        chk_eq("mr_resp_rdata", resp_rdata, 32'h0000_0077);

        // mixed: write from req0, then read from req1 at the same address
        tick();
        set_req(0, 1'b1, 32'h0000_5000, 32'hA5A5_A5A5, 4'hF);
        #1 chk_eq("mx_wr_ready", req_ready, 2'b01);
        tick();
        clr_req();
        set_req(1, 1'b0, 32'h0000_5000, 32'h0, 4'h0);
        wready = 1'b1;
        #1 chk_eq("mx_wvalid", wvalid, 1);
        chk_eq("mx_waddr", waddr, 32'h0000_5000);
        chk_eq("mx_wdata", wdata, 32'hA5A5_A5A5);
        chk_eq("mx_rvalid_issue", rvalid, 0);
        chk_eq("mx_ready_issue", req_ready, 0);
        tick();
        wready = 1'b0;
        #1 chk_eq("mx_ready_wait0", req_ready, 0);
        chk_eq("mx_rvalid_wait0", rvalid, 0);
        tick();
        #1 chk_eq("mx_ready_wait1", req_ready, 0);
        tick();
        wdone = 1'b1;
        #1 chk_eq("mx_ready_wdone", req_ready, 0);
        chk_eq("mx_resp_wdone", resp_valid, 0);
        tick();
        wdone = 1'b0;
        #1 chk_eq("mx_wr_resp", resp_valid, 2'b01);
        chk_eq("mx_rd_ready", req_ready, 2'b10);
        tick();
        clr_req();
        rready = 1'b1;
        rdone  = 1'b1;
        rdata  = 32'h0000_55AA;
        #1 chk_eq("mx_rvalid", rvalid, 1);
        chk_eq("mx_raddr", raddr, 32'h0000_5000);
        chk_eq("mx_resp_issue", resp_valid, 0);
        tick();
        clr_master();
        #1 chk_eq("mx_resp_pend", resp_valid, 0);
        tick();
        #1 chk_eq("mx_rd_resp", resp_valid, 2'b10);
        chk_eq("mx_rd_rdata", resp_rdata, 32'h0000_55AA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
